// File: rtl/ecc_sed_checker.sv
// Receive side of the single-error-detect link: checks even parity over each
// {parity, data} codeword, strips the parity bit and keeps error statistics.
module ecc_sed_checker #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned CNT_W       = 8,
    parameter bit          HALT_ON_ERR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [DATA_W:0]   enc_codeword,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    input  logic              err_clr,
    output logic              halted
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept_s;
    logic                word_err_s;

    // Odd overall parity marks a corrupted codeword.
    function automatic logic parity_odd(input logic [DATA_W:0] cw);
        return ^cw;
    endfunction

    // Handshake, output stage, statistics and FSM next-state.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        data_d     = data_q;
        err_d      = err_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        enc_ready  = (state_q == ST_RUN) && (!valid_q || dec_ready);
        accept_s   = enc_valid && enc_ready;
        word_err_s = parity_odd(enc_codeword);

        if (accept_s) begin
            valid_d = 1'b1;
            data_d  = enc_codeword[DATA_W-1:0];
            err_d   = word_err_s;
        end else if (valid_q && dec_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A fresh error outranks a simultaneous clear.
        if (accept_s && word_err_s) begin
            sticky_d = 1'b1;
            if (err_clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (err_clr) begin
            sticky_d = 1'b0;
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            sticky_d = sticky_q;
            cnt_d    = cnt_q;
        end

        case (state_q)
            ST_RUN: begin
                if (HALT_ON_ERR && accept_s && word_err_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (err_clr) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            data_q   <= {DATA_W{1'b0}};
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dec_valid  = valid_q;
    assign dec_data   = data_q;
    assign dec_err    = err_q;
    assign err_sticky = sticky_q;
    assign err_count  = cnt_q;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_ecc_sed_checker.sv
// Two checkers side by side (CNT_W=4 run-through, CNT_W=8 halt-on-error)
// compared cycle by cycle against a behavioural model of the link rules.
module tb_ecc_sed_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ev[2], rdy[2], dv[2], dr[2], de[2], st[2], clr[2], hl[2];
    logic [12:0] cw[2];
    logic [11:0] dd[2];
    logic [3:0]  cnt0;
    logic [7:0]  cnt1;

    int checks = 0;
    int errors = 0;

    bit         m_valid[2];
    logic [11:0] m_data[2];
    bit         m_err[2], m_sticky[2], m_halt[2];
    int         m_cnt[2];
    int         cnt_max[2]   = '{15, 255};
    bit         halt_mode[2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    ecc_sed_checker #(.DATA_W(12), .CNT_W(4), .HALT_ON_ERR(1'b0)) u_run (
        .clk(clk), .rst(rst), .enc_valid(ev[0]), .enc_ready(rdy[0]),
        .enc_codeword(cw[0]), .dec_valid(dv[0]), .dec_ready(dr[0]),
        .dec_data(dd[0]), .dec_err(de[0]), .err_sticky(st[0]),
        .err_count(cnt0), .err_clr(clr[0]), .halted(hl[0])
    );

    ecc_sed_checker #(.DATA_W(12), .CNT_W(8), .HALT_ON_ERR(1'b1)) u_halt (
        .clk(clk), .rst(rst), .enc_valid(ev[1]), .enc_ready(rdy[1]),
        .enc_codeword(cw[1]), .dec_valid(dv[1]), .dec_ready(dr[1]),
        .dec_data(dd[1]), .dec_err(de[1]), .err_sticky(st[1]),
        .err_count(cnt1), .err_clr(clr[1]), .halted(hl[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int d);
        return (d == 0) ? {28'd0, cnt0} : {24'd0, cnt1};
    endfunction

    function automatic logic [12:0] mkword(input bit bad);
        logic [11:0] data;
        data = 12'($urandom);
        return {(^data) ^ bad, data};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0; m_data[d] = 12'h000; m_err[d] = 1'b0;
            m_sticky[d] = 1'b0; m_halt[d] = 1'b0; m_cnt[d] = 0;
        end
    endtask

    task automatic check_outs(input int d);
        chk($sformatf("dec_valid%0d", d), {31'd0, dv[d]}, {31'd0, m_valid[d]});
        chk($sformatf("dec_data%0d", d), {20'd0, dd[d]}, {20'd0, m_data[d]});
        chk($sformatf("dec_err%0d", d), {31'd0, de[d]}, {31'd0, m_err[d]});
        chk($sformatf("err_sticky%0d", d), {31'd0, st[d]}, {31'd0, m_sticky[d]});
        chk($sformatf("err_count%0d", d), cnt_of(d), m_cnt[d]);
        chk($sformatf("halted%0d", d), {31'd0, hl[d]}, {31'd0, m_halt[d]});
    endtask

    task automatic step();
        bit acc[2];
        bit exp_rdy;
        bit bad;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rdy = !m_halt[d] && (!m_valid[d] || dr[d]);
            chk($sformatf("enc_ready%0d", d), {31'd0, rdy[d]}, {31'd0, exp_rdy});
            acc[d] = ev[d] && exp_rdy;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            bad = ($countones(cw[d]) % 2) == 1;
            if (acc[d]) begin
                m_valid[d] = 1'b1;
                m_data[d]  = cw[d][11:0];
                m_err[d]   = bad;
            end else if (m_valid[d] && dr[d]) begin
                m_valid[d] = 1'b0;
            end
            if (acc[d] && bad) begin
                m_cnt[d]    = clr[d] ? 1 : ((m_cnt[d] < cnt_max[d]) ? m_cnt[d] + 1 : m_cnt[d]);
                m_sticky[d] = 1'b1;
                if (halt_mode[d]) m_halt[d] = 1'b1;
            end else if (clr[d]) begin
                m_cnt[d] = 0; m_sticky[d] = 1'b0; m_halt[d] = 1'b0;
            end
            check_outs(d);
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            ev[d] = 1'b0; dr[d] = 1'b1; clr[d] = 1'b0;
        end
    endtask

    task automatic put(input int d, input logic [12:0] w);
        ev[d] = 1'b1;
        cw[d] = w;
    endtask

    initial begin
        cw[0] = 13'h0000; cw[1] = 13'h0000;
        idle();
        model_reset();
        #12;
        check_outs(0); check_outs(1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Clean and corrupted directed words
        put(0, 13'h0FFF); put(1, 13'h1001); step();
        chk("t2_data_fff", {20'd0, dd[0]}, 32'h0000_0FFF);
        chk("t2_err_fff", {31'd0, de[0]}, 32'd0);
        put(0, 13'h1001); ev[1] = 1'b0; step();
        chk("t2_data_001", {20'd0, dd[0]}, 32'h0000_0001);
        chk("t2_err_001", {31'd0, de[0]}, 32'd0);
        put(0, 13'h0001); step();
        chk("t2_err_bad", {31'd0, de[0]}, 32'd1);
        chk("t2_cnt_bad", cnt_of(0), 32'd1);
        chk("t2_sticky_bad", {31'd0, st[0]}, 32'd1);
        idle(); step();

        // Backpressure: held output, no intake, then full-rate streaming
        dr[0] = 1'b0; put(0, mkword(1'b0)); step();
        put(0, mkword(1'b0));
        for (int i = 0; i < 5; i++) step();
        dr[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            put(0, mkword($urandom_range(3, 0) == 0));
            step();
        end

        // Counter saturation at 15
        idle(); clr[0] = 1'b1; step(); clr[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            put(0, mkword(1'b1));
            step();
        end
        chk("t4_saturated", cnt_of(0), 32'd15);
        idle(); clr[0] = 1'b1; step(); clr[0] = 1'b0;
        chk("t4_cleared", cnt_of(0), 32'd0);
        chk("t4_sticky_clr", {31'd0, st[0]}, 32'd0);

        // Halt on error, drain, clear, resume
        put(1, 13'h0001); step();
        chk("t5_halted", {31'd0, hl[1]}, 32'd1);
        chk("t5_err_out", {31'd0, de[1]}, 32'd1);
        put(1, 13'h0FFF); dr[1] = 1'b0; step(); step();
        dr[1] = 1'b1; step(); step();
        clr[1] = 1'b1; step(); clr[1] = 1'b0;
        chk("t5_unhalted", {31'd0, hl[1]}, 32'd0);
        step();
        chk("t5_resumed", {20'd0, dd[1]}, 32'h0000_0FFF);

        // Clear colliding with an accepted errored word
        idle(); clr[0] = 1'b1; step(); clr[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            put(0, mkword(1'b1));
            step();
        end
        chk("t6_cnt7", cnt_of(0), 32'd7);
        put(0, mkword(1'b1)); clr[0] = 1'b1;
        put(1, mkword(1'b1)); clr[1] = 1'b1;
        step();
        chk("t6_cnt_run", cnt_of(0), 32'd1);
        chk("t6_sticky_run", {31'd0, st[0]}, 32'd1);
        chk("t6_cnt_halt", cnt_of(1), 32'd1);
        chk("t6_halted", {31'd0, hl[1]}, 32'd1);
        idle(); clr[1] = 1'b1; step(); clr[1] = 1'b0;

        // Randomised traffic on both instances
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 2; d++) begin
                ev[d]  = $urandom_range(3, 0) != 0;
                cw[d]  = mkword($urandom_range(3, 0) == 0);
                dr[d]  = $urandom_range(3, 0) != 0;
                clr[d] = $urandom_range(19, 0) == 0;
            end
            step();
        end

        // Asynchronous reset mid-transfer, then first word after release
        idle(); put(0, mkword(1'b0)); put(1, mkword(1'b0));
        step(); step();
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outs(0); check_outs(1);
        #3;
        rst = 1'b1;
        put(0, 13'h0ABC ^ {^12'hABC, 12'h000}); put(1, mkword(1'b0));
        step();
        chk("t1_first_valid", {31'd0, dv[0]}, 32'd1);
        idle(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
